// File: rtl/audio_info_frame_rx.sv
// Audio InfoFrame (type 0x84) receive parser: validates header and checksum,
// then atomically publishes the decoded audio fields on acceptance.
module audio_info_frame_rx #(
  parameter bit         CHECK_VERSION   = 1'b1,
  parameter logic [4:0] EXPECTED_LENGTH = 5'd10
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic       in_valid,
  input  logic       in_start,
  input  logic [7:0] in_data,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       info_present,
  output logic [3:0] coding_type,
  output logic [2:0] channel_count,
  output logic [2:0] sampling_frequency,
  output logic [1:0] sample_size,
  output logic [7:0] channel_allocation,
  output logic       down_mix_inhibited,
  output logic [3:0] level_shift_value,
  output logic [1:0] lfe_playback_level
);

  typedef enum logic [1:0] {IDLE, HDR, BODY, SKIP} state_t;

  localparam logic [4:0] LAST_IDX = 5'd30;

  state_t     state, state_nxt;
  logic [4:0] idx, idx_nxt;
  logic [7:0] sum, sum_nxt;
  logic       hdr_bad, hdr_bad_nxt;
  logic       ok_nxt, err_nxt;
  logic [1:0] code_nxt;

  logic [7:0] sum_add;
  logic [4:0] pb_idx;
  logic       cap_pb1, cap_pb2, cap_pb4, cap_pb5;

  // Shadow copies hold only the bits that are eventually published.
  logic [6:0] sh_pb1;
  logic [4:0] sh_pb2;
  logic [7:0] sh_pb4;
  logic [6:0] sh_pb5;

  assign sum_add = sum + in_data;
  assign pb_idx  = idx - 5'd3;

  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    sum_nxt     = sum;
    hdr_bad_nxt = hdr_bad;
    ok_nxt      = 1'b0;
    err_nxt     = 1'b0;
    code_nxt    = err_code;
    cap_pb1     = 1'b0;
    cap_pb2     = 1'b0;
    cap_pb4     = 1'b0;
    cap_pb5     = 1'b0;

    if (in_valid) begin
      if (in_start) begin
        // An interrupted Audio InfoFrame is reported; the start byte is then
        // handled as a fresh packet in the same cycle.
        if (state == HDR || state == BODY) begin
          err_nxt  = 1'b1;
          code_nxt = 2'd3;
        end
        state_nxt   = (in_data == 8'h84) ? HDR : SKIP;
        idx_nxt     = 5'd1;
        sum_nxt     = in_data;
        hdr_bad_nxt = 1'b0;
      end else begin
        unique case (state)
          IDLE: ;
          HDR: begin
            sum_nxt = sum_add;
            idx_nxt = idx + 5'd1;
            if (idx == 5'd1 && CHECK_VERSION && in_data != 8'h01)
              hdr_bad_nxt = 1'b1;
            if (idx == 5'd2) begin
              if (in_data[4:0] != EXPECTED_LENGTH)
                hdr_bad_nxt = 1'b1;
              state_nxt = BODY;
            end
          end
          BODY: begin
            if (pb_idx <= EXPECTED_LENGTH)
              sum_nxt = sum_add;
            cap_pb1 = (pb_idx == 5'd1);
            cap_pb2 = (pb_idx == 5'd2);
            cap_pb4 = (pb_idx == 5'd4);
            cap_pb5 = (pb_idx == 5'd5);
            if (idx == LAST_IDX) begin
              state_nxt = IDLE;
              idx_nxt   = '0;
              if (hdr_bad) begin
                err_nxt  = 1'b1;
                code_nxt = 2'd1;
              end else if (sum_nxt != 8'h00) begin
                err_nxt  = 1'b1;
                code_nxt = 2'd2;
              end else begin
                ok_nxt   = 1'b1;
                code_nxt = 2'd0;
              end
            end else begin
              idx_nxt = idx + 5'd1;
            end
          end
          SKIP: begin
            if (idx == LAST_IDX) begin
              state_nxt = IDLE;
              idx_nxt   = '0;
            end else begin
              idx_nxt = idx + 5'd1;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      idx       <= '0;
      sum       <= '0;
      hdr_bad   <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      sum       <= sum_nxt;
      hdr_bad   <= hdr_bad_nxt;
      frame_ok  <= ok_nxt;
      frame_err <= err_nxt;
      err_code  <= code_nxt;
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      sh_pb1 <= '0;
      sh_pb2 <= '0;
      sh_pb4 <= '0;
      sh_pb5 <= '0;
    end else begin
      if (cap_pb1) sh_pb1 <= {in_data[7:4], in_data[2:0]};
      if (cap_pb2) sh_pb2 <= in_data[4:0];
      if (cap_pb4) sh_pb4 <= in_data;
      if (cap_pb5) sh_pb5 <= {in_data[7:3], in_data[1:0]};
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      info_present       <= 1'b0;
      coding_type        <= '0;
      channel_count      <= '0;
      sampling_frequency <= '0;
      sample_size        <= '0;
      channel_allocation <= '0;
      down_mix_inhibited <= 1'b0;
      level_shift_value  <= '0;
      lfe_playback_level <= '0;
    end else if (ok_nxt) begin
      info_present       <= 1'b1;
      coding_type        <= sh_pb1[6:3];
      channel_count      <= sh_pb1[2:0];
      sampling_frequency <= sh_pb2[4:2];
      sample_size        <= sh_pb2[1:0];
      channel_allocation <= sh_pb4;
      down_mix_inhibited <= sh_pb5[6];
      level_shift_value  <= sh_pb5[5:2];
      lfe_playback_level <= sh_pb5[1:0];
    end
  end

endmodule
